// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue shared types: FSM state, FIFO entry, boot PC.
// Optional feature macro: IFQ_BYPASS_EN (see ifetch_queue.sv).
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RSP,
    DROP
  } ifq_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  localparam logic [31:0] IFQ_BOOT_PC = 32'h0000_3000;

endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue bundle: PC control, imem bus, instruction output.
// master = the fetch queue, slave = PC reg / memory / decoder side.
interface ifetch_queue_if;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  modport master (
    input  pc_i, imem_gnt_i, imem_rvalid_i,
    input  imem_rdata_i, redirect_i, instr_ready_i,
    output pc_en_o, imem_req_o, imem_addr_o,
    output instr_valid_o, instr_o, instr_pc_o
  );

  modport slave (
    output pc_i, imem_gnt_i, imem_rvalid_i,
    output imem_rdata_i, redirect_i, instr_ready_i,
    input  pc_en_o, imem_req_o, imem_addr_o,
    input  instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: instruction entry FIFO with push/pop/flush.
// DEPTH must be a power of two so pointers wrap naturally.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  ifq_entry_t               wdata,
  input  logic                     pop,
  output ifq_entry_t               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifq_entry_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop_ok;

  assign empty  = count == '0;
  assign pop_ok = pop && !empty;
  assign rdata  = mem[rd_ptr];

  // pointers and occupancy; flush wins over push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + CW'(push) - CW'(pop_ok);
    end
  end

  // entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: single-outstanding imem fetcher feeding a FIFO.
// `define IFQ_BYPASS_EN forwards a response straight to an empty output.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] BOOT_PC = IFQ_BOOT_PC
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_t     state;
  logic           kill;
  logic           pending;
  logic           req_q;
  logic [31:0]    addr_q;
  logic           rsp_ok;
  logic           bypass;
  logic           push;
  logic           pop;
  logic           empty;
  logic           has_room;
  logic [CW-1:0]  count;
  logic [CW-1:0]  cnt_nxt;
  ifq_entry_t     head;
  ifq_entry_t     wdata;

  assign rsp_ok = state == WAIT_RSP && bus.imem_rvalid_i
                  && !bus.redirect_i;
`ifdef IFQ_BYPASS_EN
  assign bypass = rsp_ok && empty;
`else
  assign bypass = 1'b0;
`endif
  assign pop   = bus.instr_ready_i && !empty;
  assign push  = rsp_ok && !(bypass && bus.instr_ready_i);
  assign wdata = {addr_q, bus.imem_rdata_i};

  assign cnt_nxt  = count + CW'(push) - CW'(pop);
  assign has_room = ({1'b0, count} + (CW+1)'(pending))
                    < (CW+1)'(DEPTH);

  assign bus.imem_req_o  = req_q;
  assign bus.imem_addr_o = addr_q;
  assign bus.pc_en_o     = state == WAIT_GNT && bus.imem_gnt_i
                           && !kill && !bus.redirect_i;

  assign bus.instr_valid_o = !empty || bypass;
  assign bus.instr_o    = bypass ? bus.imem_rdata_i
                        : empty  ? 32'h0 : head.instr;
  assign bus.instr_pc_o = bypass ? addr_q
                        : empty  ? BOOT_PC : head.pc;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect_i),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  // fetch FSM: issue, wait grant, wait response, drop stale response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      kill    <= 1'b0;
      pending <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.redirect_i && has_room) begin
            state  <= WAIT_GNT;
            req_q  <= 1'b1;
            addr_q <= {bus.pc_i[31:2], 2'b00};
          end
        end
        WAIT_GNT: begin
          if (bus.imem_gnt_i) begin
            req_q <= 1'b0;
            kill  <= 1'b0;
            if (kill || bus.redirect_i) begin
              state <= DROP;
            end else begin
              state   <= WAIT_RSP;
              pending <= 1'b1;
            end
          end else if (bus.redirect_i) begin
            kill <= 1'b1;
          end
        end
        WAIT_RSP: begin
          if (bus.redirect_i) begin
            pending <= 1'b0;
            state   <= bus.imem_rvalid_i ? IDLE : DROP;
          end else if (bus.imem_rvalid_i) begin
            pending <= 1'b0;
            if (cnt_nxt < CW'(DEPTH)) begin
              state  <= WAIT_GNT;
              req_q  <= 1'b1;
              addr_q <= {bus.pc_i[31:2], 2'b00};
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (bus.imem_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, instruction FIFO entries; power of two, 2..16.
REQ-002 Parameter BOOT_PC, default 32'h0000_3000, value driven on instr_pc_o while the queue is empty.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 pc_i  in  32  current PC from the PC register.
REQ-006 pc_en_o  out  1  one-cycle pulse: PC register loads its next value.
REQ-007 imem_req_o  out  1  instruction memory read request.
REQ-008 imem_addr_o  out  32  word address, {pc_i[31:2],2'b00} captured at issue.
REQ-009 imem_gnt_i  in  1  memory accepted the request this cycle.
REQ-010 imem_rvalid_i  in  1  read data valid, exactly one per grant, in order.
REQ-011 imem_rdata_i  in  32  instruction word.
REQ-012 redirect_i  in  1  branch/jump/flush; PC register loads the target this cycle.
REQ-013 instr_valid_o  out  1  head entry valid.
REQ-014 instr_o  out  32  head instruction.
REQ-015 instr_pc_o  out  32  PC of head instruction.
REQ-016 instr_ready_i  in  1  consumer pops head when instr_valid_o && instr_ready_i.

Function
REQ-017 FSM states: IDLE, WAIT_GNT, WAIT_RSP, DROP.
REQ-018 IDLE -> WAIT_GNT when redirect_i=0 and fifo_count + pending < DEPTH; address captured from pc_i that cycle.
REQ-019 In WAIT_GNT: imem_req_o=1, imem_addr_o stable until imem_gnt_i.
REQ-020 WAIT_GNT + gnt -> WAIT_RSP and pc_en_o=1 in that same cycle; one outstanding request maximum.
REQ-021 WAIT_RSP + rvalid -> push {addr,rdata} into FIFO, -> IDLE (or WAIT_GNT directly if space remains).
REQ-022 redirect_i in any state: FIFO emptied that cycle, instr_valid_o=0 next cycle.
REQ-023 redirect_i in WAIT_GNT: request held until gnt, then DROP; pc_en_o NOT pulsed for that grant.
REQ-024 redirect_i in WAIT_RSP (no rvalid same cycle) -> DROP; the next rvalid is discarded, then -> IDLE.
REQ-025 redirect_i coincident with rvalid in WAIT_RSP: data discarded, -> IDLE.
REQ-026 Simultaneous push and pop with FIFO full is illegal by construction; with FIFO non-full, both occur, count unchanged.
REQ-027 FIFO pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
REQ-028 Pop on empty FIFO has no effect; instr_pc_o=BOOT_PC when empty, instr_o=0.
REQ-029 Minimum latency pc issue -> instr_valid_o: gnt cycle + rvalid cycle + 1 (registered FIFO).

Reset
REQ-030 On reset: state IDLE, FIFO empty, pending=0, pc_en_o=0, imem_req_o=0, imem_addr_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=BOOT_PC.
REQ-031 Reset mid-transaction abandons it; rvalid for a pre-reset grant is the memory's responsibility to suppress.

Configuration
REQ-032 Macro IFQ_BYPASS_EN defined: when FIFO empty, state WAIT_RSP, rvalid=1 and redirect_i=0, rdata/addr forwarded combinationally to instr_o/instr_pc_o with instr_valid_o=1; if instr_ready_i also 1 no FIFO write occurs.
REQ-033 Macro undefined: responses always written to FIFO, visible next cycle; no rdata-to-output combinational path.

Structure
REQ-034 Package ifq_pkg: state enum ifq_state_t, entry struct ifq_entry_t {pc[31:0], instr[31:0]}, constant IFQ_BOOT_PC=32'h0000_3000.
REQ-035 Sub-module ifq_fifo (synchronous push/pop/flush, count, DEPTH parameter) holds entries; FSM lives in ifetch_queue.

Verification
REQ-036 Reset, pc_i=0x3000, gnt and rvalid one cycle each, rdata=0x3C010001 -> one pc_en_o pulse, instr_valid_o=1 with instr_pc_o=0x3000 at REQ-029 latency.
REQ-037 instr_ready_i=0, continuous gnt/rvalid -> exactly DEPTH=4 entries stored, imem_req_o stays 0 afterwards, pops restart fetch.
REQ-038 gnt held low 5 cycles -> imem_req_o and imem_addr_o=0x3004 stable throughout, pc_en_o=0 until gnt.
REQ-039 redirect_i in WAIT_RSP, then rvalid rdata=0xDEADBEEF -> word discarded, FIFO empty, next fetch uses new pc_i=0x3100.
REQ-040 redirect_i coincident with push and pop on 3-entry FIFO -> count 0, instr_valid_o=0 next cycle.
REQ-041 Both IFQ_BYPASS_EN builds: empty FIFO, rvalid with ready=1 -> instr_valid_o same cycle (defined) vs next cycle (undefined).
